// File: rtl/mux_rr_pkg.sv
// Shared mode encodings and index helpers for the round-robin selector stage.
package mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Increment modulo n; n need not be a power of two.
    function automatic int unsigned mod_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating priority encoder: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic                gnt_valid,
    output logic [SEL_W-1:0]    gnt_idx
);

    localparam int IW = SEL_W + 1;

    logic [IW-1:0]    rot_sum [CHANNELS];
    logic [SEL_W-1:0] rot_idx [CHANNELS];

    // rot_idx[k] is the channel visited k steps after ptr; ptr < CHANNELS so one subtract wraps.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_rot
        assign rot_sum[gi] = {1'b0, ptr} + IW'(gi);
        assign rot_idx[gi] = (rot_sum[gi] >= IW'(CHANNELS))
                           ? SEL_W'(rot_sum[gi] - IW'(CHANNELS))
                           : rot_sum[gi][SEL_W-1:0];
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (req[rot_idx[k]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/mux_rr_stage.sv
// N:1 valid/ready selector with fixed-select and round-robin modes into one output register.
module mux_rr_stage
    import mux_rr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready
);

    localparam int VP = 1 << SEL_W;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [SEL_W-1:0] out_sel_reg;
    logic [SEL_W-1:0] rr_ptr_reg;

    logic             load_en;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic [VP-1:0]    valid_pad;
    logic             fixed_valid;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] ch_data [CHANNELS];

    rr_arbiter #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_reg),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Zero-padding to 2**SEL_W entries makes any sel >= CHANNELS read as "not valid".
    assign valid_pad   = VP'(in_valid);
    assign fixed_valid = valid_pad[sel];

    assign gnt_valid = (mode == MODE_RR) ? rr_valid : fixed_valid;
    assign gnt_idx   = (mode == MODE_RR) ? rr_idx   : sel;
    assign load_en   = !out_valid_reg | out_ready;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
        assign in_ready[gi] = rst_n & load_en & gnt_valid & (gnt_idx == SEL_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            rr_ptr_reg    <= '0;
        end else if (load_en) begin
            if (gnt_valid) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= ch_data[gnt_idx];
                out_sel_reg   <= gnt_idx;
                if (mode == MODE_RR)
                    rr_ptr_reg <= SEL_W'(mod_inc(32'(gnt_idx), CHANNELS));
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_mux_rr_stage.sv
// Directed vector bench for mux_rr_stage at CHANNELS=4 plus a CHANNELS=3 instance.
module tb_mux_rr_stage;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [23:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_ready3;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mux_rr_stage #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    mux_rr_stage #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3),
        .out_ready(out_ready3)
    );

    typedef struct {
        logic       m;
        logic [1:0] s;
        logic [3:0] v;
        logic       r;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [7:0] e_d;
        logic [1:0] e_s;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v,
                                input logic r, input logic [3:0] e_rdy, input logic e_ov,
                                input logic [7:0] e_d, input logic [1:0] e_s);
        vec_t x;
        x.m = m; x.s = s; x.v = v; x.r = r;
        x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_d = e_d; x.e_s = e_s;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, check in_ready, then check the registered output after the rise.
    task automatic step(input string tag, input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic r, input logic [3:0] e_rdy, input logic e_ov,
                        input logic [7:0] e_d, input logic [1:0] e_s);
        mode = m; sel = s; in_valid = v; out_ready = r;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
        @(posedge clk); #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".out_data"}, 32'(out_data), 32'(e_d));
        chk({tag, ".out_sel"}, 32'(out_sel), 32'(e_s));
        $display("vec %s: mode=%0d sel=%0d v=%b rdy=%b -> ov=%0d d=%02h s=%0d",
                 tag, m, s, v, in_ready, out_valid, out_data, out_sel);
        @(negedge clk);
    endtask

    task automatic step3(input string tag, input logic m, input logic [1:0] s, input logic [2:0] e_rdy,
                         input logic e_ov, input logic [7:0] e_d, input logic [1:0] e_s);
        mode3 = m; sel3 = s; in_valid3 = 3'b111; out_ready3 = 1'b1;
        #1;
        chk({tag, ".in_ready3"}, 32'(in_ready3), 32'(e_rdy));
        @(posedge clk); #1;
        chk({tag, ".out_valid3"}, 32'(out_valid3), 32'(e_ov));
        if (e_ov) begin
            chk({tag, ".out_data3"}, 32'(out_data3), 32'(e_d));
            chk({tag, ".out_sel3"}, 32'(out_sel3), 32'(e_s));
        end
        $display("vec %s: c3 mode=%0d sel=%0d -> ov=%0d d=%02h s=%0d",
                 tag, m, s, out_valid3, out_data3, out_sel3);
        @(negedge clk);
    endtask

    initial begin
        // Fixed select on ch2, then an invalid selected channel, then round-robin patterns.
        for (int k = 0; k < 3; k++) vecs.push_back(mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2));
        for (int k = 0; k < 2; k++) vecs.push_back(mk(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 8'h12, 2'd2));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b1, 8'(8'h10 + k % 4), 2'(k % 4)));
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) vecs.push_back(mk(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1));
            else            vecs.push_back(mk(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3));
        end
        vecs.push_back(mk(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3));

        rst_n = 1'b0;
        mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b1;
        in_data3 = {8'h32, 8'h31, 8'h30};
        #2;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_data", 32'(out_data), 32'd0);
        chk("reset.out_sel", 32'(out_sel), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("tbl%0d", i), vecs[i].m, vecs[i].s, vecs[i].v, vecs[i].r,
                 vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_d, vecs[i].e_s);

        // Backpressure: first RR load on ch0, hold five cycles, then ch1 follows without a bubble.
        step("bp.load", 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0);
        for (int k = 0; k < 5; k++)
            step($sformatf("bp.hold%0d", k), 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0);
        step("bp.release", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);

        // Mode switch: pointer now 2; fixed transfers must not move it.
        step("ms.fix0", 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
        step("ms.fix1", 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
        step("ms.rr", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
        step("ms.drain", 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h12, 2'd2);

        // Three-channel instance: out-of-range sel never grants, RR wraps 2 -> 0.
        step3("c3.sel3a", 1'b0, 2'd3, 3'b000, 1'b0, 8'h00, 2'd0);
        step3("c3.sel3b", 1'b0, 2'd3, 3'b000, 1'b0, 8'h00, 2'd0);
        step3("c3.sel2", 1'b0, 2'd2, 3'b100, 1'b1, 8'h32, 2'd2);
        for (int k = 0; k < 4; k++)
            step3($sformatf("c3.rr%0d", k), 1'b1, 2'd0, 3'(1 << (k % 3)), 1'b1, 8'(8'h30 + k % 3), 2'(k % 3));
        in_valid3 = 3'b000;

        // Asynchronous reset while a word is held.
        in_data[7:0] = 8'hA5;
        step("rst.load", 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA5, 2'd0);
        out_ready = 1'b1; in_valid = 4'b1111; sel = 2'd3;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        chk("rst.out_sel", 32'(out_sel), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.out_valid3", 32'(out_valid3), 32'd0);
        $display("vec rst: ov=%0d d=%02h s=%0d rdy=%b", out_valid, out_data, out_sel, in_ready);
        @(posedge clk); #1;
        chk("rst.in_ready_held", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
